// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller: double-buffered display value, per-slot
// anti-ghosting guard window, leading-zero suppression and invalid-BCD flagging.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  output logic                    in_ready,
  input  logic                    lz_blank,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    bad_digit,
  output logic [1:0]              dbg_state
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {OFF = 2'd0, GUARD = 2'd1, SHOW = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [DW-1:0]   active_q, active_d, pend_q, pend_d;
  logic            pfull_q, pfull_d, lz_q, lz_d;
  logic            accept;

  logic [3:0]            num_d;
  logic [NUM_DIGITS-1:0] en_d, supp;
  logic                  fd_d, bad_d, zero_above;

  // Handshake: a value transfers on a rising edge where in_valid && in_ready;
  // in_valid may be held high and in_data must stay stable until it transfers.
  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    active_d = active_q;
    pend_d   = pend_q;
    pfull_d  = pfull_q;
    lz_d     = lz_q;
    case (state_q)
      OFF: begin
        if (accept) begin
          active_d = in_data;
          lz_d     = lz_blank;
          cnt_d    = '0;
          slot_d   = '0;
          state_d  = (GUARD_CYCLES > 0) ? GUARD : SHOW;
        end
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
          // Frame boundary: the only point where a new value may take over.
          if (slot_q == SLOT_LAST) begin
            lz_d = lz_blank;
            if (pfull_q) begin
              active_d = pend_q;
              pfull_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (accept) begin
          pend_d  = in_data;
          pfull_d = 1'b1;
        end
        state_d = (cnt_d < CNT_GUARD) ? GUARD : SHOW;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered outputs line up
  // with the registered state in the same cycle.
  always_comb begin
    num_d      = '0;
    en_d       = '0;
    bad_d      = 1'b0;
    supp       = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (active_d[4*i +: 4] == 4'd0);
      supp[i]    = lz_d && zero_above;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (active_d[4*i +: 4] > 4'd9) bad_d = 1'b1;
      if (state_d != OFF && slot_d == SW'(i)) begin
        num_d = active_d[4*i +: 4];
        if (state_d == SHOW && !supp[i]) en_d[i] = 1'b1;
      end
    end
    fd_d = (state_d != OFF) && (slot_d == SLOT_LAST) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      slot_q     <= '0;
      active_q   <= '0;
      pend_q     <= '0;
      pfull_q    <= 1'b0;
      lz_q       <= 1'b0;
      num        <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      bad_digit  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pfull_q    <= pfull_d;
      lz_q       <= lz_d;
      num        <= num_d;
      digit_en   <= en_d;
      frame_done <= fd_d;
      bad_digit  <= bad_d;
      in_ready   <= !pfull_d;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus random traffic,
// compared every cycle against a frame-time based reference model.
module tb_display_scan_controller;

  localparam int N     = 4;
  localparam int S     = 8;
  localparam int G     = 2;
  localparam int FRAME = N * S;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [4*N-1:0] in_data = '0;
  logic          lz_blank = 1'b0;
  logic          in_ready, frame_done, bad_digit;
  logic [3:0]    num;
  logic [N-1:0]  digit_en;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: display time is a position within the frame.
  bit             m_on;
  logic [4*N-1:0] m_act;
  logic [4*N-1:0] m_pend_q[$];
  bit             m_lz;
  int             m_t;
  bit             m_acc;

  display_scan_controller #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lz_blank(lz_blank), .num(num), .digit_en(digit_en),
    .frame_done(frame_done), .bad_digit(bad_digit), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [4*N-1:0] v, input int i);
    return v[4*i +: 4];
  endfunction

  task automatic model_reset();
    m_on  = 1'b0;
    m_act = '0;
    m_pend_q.delete();
    m_lz  = 1'b0;
    m_t   = 0;
    m_acc = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc   = in_valid && (m_pend_q.size() == 0);
      m_acc = acc;
      if (!m_on) begin
        if (acc) begin
          m_on  = 1'b1;
          m_act = in_data;
          m_t   = 0;
          m_lz  = lz_blank;
        end
      end else begin
        if (m_t == FRAME - 1) begin
          m_t  = 0;
          m_lz = lz_blank;
          if (m_pend_q.size() > 0) m_act = m_pend_q.pop_front();
        end else begin
          m_t++;
        end
        if (acc) m_pend_q.push_back(in_data);
      end
    end
  endtask

  task automatic compare();
    int slot, pos;
    bit supp, bad;
    logic [3:0]   e_num;
    logic [N-1:0] e_en;
    bit           e_fd;
    e_num = '0; e_en = '0; e_fd = 1'b0; bad = 1'b0;
    slot = m_t / S;
    pos  = m_t % S;
    for (int i = 0; i < N; i++) if (nib(m_act, i) > 4'd9) bad = 1'b1;
    if (m_on) begin
      e_num = nib(m_act, slot);
      supp  = m_lz && slot > 0 && ((m_act >> (4 * slot)) == '0);
      if (pos >= G && !supp) e_en = N'(1) << slot;
      e_fd = (m_t == FRAME - 1);
    end
    check("in_ready", in_ready, (m_pend_q.size() == 0));
    check("num", num, e_num);
    check("digit_en", digit_en, e_en);
    check("frame_done", frame_done, e_fd);
    check("bad_digit", bad_digit, bad);
    check("onehot0", $onehot0(digit_en), 1);
    if (m_on && pos < G) check("guard_dark", digit_en, 0);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [4*N-1:0] v);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int n = 0; n < 4 * FRAME; n++) begin
      cycle();
      if (m_acc) begin
        got = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("send_accepted", got, 1);
  endtask

  // Assert reset asynchronously mid-cycle and check outputs before any clock edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_num", num, 0);
    check("rst_digit_en", digit_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_bad_digit", bad_digit, 0);
    check("rst_in_ready", in_ready, 1);
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    bit reached;
    logic [4*N-1:0] v;
    int lead;
    model_reset();
    #2;
    reset_pulse();
    run(5);

    // Basic scan of 0x1234 over two frames.
    lz_blank = 1'b0;
    send(16'h1234);
    run(2 * FRAME);

    // Leading-zero suppression on, then off.
    lz_blank = 1'b1;
    send(16'h0050);
    run(2 * FRAME);
    lz_blank = 1'b0;
    run(2 * FRAME);

    // Back-to-back values: no mixed frames, held in_valid waits for a free buffer.
    send(16'h1111);
    run(FRAME + 5);
    send(16'h2222);
    send(16'h3333);
    run(2 * FRAME);

    // Invalid BCD passed through and flagged, then cleared.
    send(16'h00A7);
    run(FRAME + 3);
    send(16'h0007);
    run(2 * FRAME);

    // Reset during SHOW of slot 2 with the pending buffer full.
    send(16'h4321);
    send(16'h5678);
    reached = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (m_on && m_t / S == 2 && m_t % S >= G) begin
        reached = 1'b1;
        break;
      end
      cycle();
    end
    check("reached_slot2_show", reached, 1);
    #3;
    reset_pulse();
    run(FRAME);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      lead = $urandom_range(0, N);
      v = '0;
      for (int i = 0; i < N; i++)
        if (i < N - lead)
          v[4*i +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      in_data  = v;
      lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) begin
        #3;
        reset_pulse();
      end
      cycle();
    end
    in_valid = 1'b0;
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
